// File: rtl/zero_pad_stream_if.sv
// zero_pad_stream_if: pixel stream into and out of the zero-pad engine
interface zero_pad_stream_if #(parameter int DATA_W = 32);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    modport master (output in_data, in_valid, out_ready, input in_ready, out_data, out_valid, out_last);
    modport slave  (input in_data, in_valid, out_ready, output in_ready, out_data, out_valid, out_last);
endinterface

// File: rtl/zero_pad_stream.sv
// zero_pad_stream: streams a SIZE x SIZE map out as a dilated, zero-padded OUT x OUT map
module zero_pad_stream #(
    parameter int DATA_W = 32,
    parameter int SIZE   = 5,
    parameter int DILATE = 1,
    parameter int PAD    = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             start,
    output logic             busy,
    output logic             done,
    zero_pad_stream_if.slave s
);
    localparam int OUT = 2*PAD + SIZE + (SIZE-1)*DILATE;
    localparam int CW  = $clog2(OUT+1);
    localparam int PW  = DILATE > 0 ? $clog2(DILATE+1) : 1;
    localparam logic [CW-1:0] L_OUT  = CW'(OUT);
    localparam logic [CW-1:0] L_LAST = CW'(OUT-1);
    localparam logic [CW-1:0] L_PAD  = CW'(PAD);
    localparam logic [CW-1:0] L_SPAN = CW'(OUT-2*PAD);
    localparam logic [PW-1:0] L_DIL  = PW'(DILATE);
    localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2;

    logic [1:0]        r_state;
    logic [CW-1:0]     r_r, r_c, w_r_off, w_c_off, w_r_nxt, w_c_nxt;
    logic [PW-1:0]     r_pr, r_pc, w_pr_nxt, w_pc_nxt;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid, r_out_last;
    logic              w_run, w_row_in, w_col_in, w_data_pos, w_gen, w_room, w_load, w_xfer;

    // Offsets wrap to large values below PAD, so one compare covers both region edges.
    always_comb begin
        w_run      = en && r_state == S_RUN;
        w_r_off    = r_r - L_PAD;
        w_c_off    = r_c - L_PAD;
        w_row_in   = w_r_off < L_SPAN;
        w_col_in   = w_c_off < L_SPAN;
        w_data_pos = w_row_in && w_col_in && r_pr == '0 && r_pc == '0;
        w_gen      = r_r != L_OUT;
        w_room     = !r_out_valid || s.out_ready;
        w_load     = w_run && w_room && w_gen && (!w_data_pos || s.in_valid);
        w_xfer     = en && r_out_valid && s.out_ready;
        w_c_nxt    = r_c == L_LAST ? '0 : r_c + 1'b1;
        w_r_nxt    = r_r + 1'b1;
        w_pc_nxt   = w_c_nxt == L_PAD ? '0 : !w_col_in ? r_pc : r_pc == L_DIL ? '0 : r_pc + 1'b1;
        w_pr_nxt   = w_r_nxt == L_PAD ? '0 : !w_row_in ? r_pr : r_pr == L_DIL ? '0 : r_pr + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_r         <= '0;
            r_c         <= '0;
            r_pr        <= '0;
            r_pc        <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (en) begin
            if (r_state == S_IDLE && start) begin
                r_state <= S_RUN;
                r_r     <= '0;
                r_c     <= '0;
                r_pr    <= '0;
                r_pc    <= '0;
            end else if (r_state == S_RUN && w_xfer && r_out_last)
                r_state <= S_DONE;
            else if (r_state == S_DONE)
                r_state <= S_IDLE;
            if (w_load) begin
                r_out_data  <= w_data_pos ? s.in_data : '0;
                r_out_last  <= r_r == L_LAST && r_c == L_LAST;
                r_out_valid <= 1'b1;
                r_c         <= w_c_nxt;
                r_pc        <= w_pc_nxt;
                if (r_c == L_LAST) begin
                    r_r  <= w_r_nxt;
                    r_pr <= w_pr_nxt;
                end
            end else if (w_xfer)
                r_out_valid <= 1'b0;
        end
    end

    assign s.in_ready  = w_run && w_room && w_data_pos;
    assign s.out_data  = r_out_data;
    assign s.out_valid = r_out_valid;
    assign s.out_last  = r_out_last;
    assign busy        = r_state == S_RUN;
    assign done        = r_state == S_DONE;
endmodule

// File: tb/tb_zero_pad_stream.sv
// tb_zero_pad_stream: scoreboard bench for the default 5->9 map and a 3->5 padded map
module tb_zero_pad_stream;
    logic clk = 0, reset = 1, en = 1, start = 0, busy, done;
    logic start2 = 0, busy2, done2;
    always #5 clk = ~clk;

    zero_pad_stream_if #(.DATA_W(32)) m();
    zero_pad_stream_if #(.DATA_W(32)) m2();

    zero_pad_stream dut (.clk(clk), .reset(reset), .en(en), .start(start), .busy(busy), .done(done), .s(m));
    zero_pad_stream #(.DATA_W(32), .SIZE(3), .DILATE(0), .PAD(1)) dut2 (
        .clk(clk), .reset(reset), .en(en), .start(start2), .busy(busy2), .done(done2), .s(m2));

    typedef struct packed { logic [31:0] d; logic l; } exp_t;
    exp_t q[$], q2[$];
    int n_chk = 0, n_fail = 0, n_xfer = 0;
    bit chk_on = 0, frame_on = 0, rnd = 0, abort = 0, seen_done = 0, seen_done2 = 0;
    bit prev_hold = 0, exp_done = 0, exp_done2 = 0;
    logic [31:0] pd;
    logic pl, acc2;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s at %0t", nm, $time);
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            automatic int gen = n_xfer + int'(m.out_valid);
            automatic bit xfer = en && m.out_valid && m.out_ready;
            automatic bit isd = (gen / 9) % 2 == 0 && (gen % 9) % 2 == 0;
            chk("busy", busy, frame_on);
            chk("done", done, exp_done);
            if (exp_done) seen_done = 1;
            exp_done = 0;
            chk("in_ready", m.in_ready, en && frame_on && gen < 81 && (!m.out_valid || m.out_ready) && isd);
            if (prev_hold) chk("hold", {m.out_valid, m.out_last, m.out_data}, {1'b1, pl, pd});
            prev_hold = m.out_valid && !xfer;
            pd = m.out_data;
            pl = m.out_last;
            if (xfer) begin
                if (q.size() == 0) fail("extra_out");
                else begin
                    automatic exp_t e = q.pop_front();
                    chk("out_data", m.out_data, e.d);
                    chk("out_last", m.out_last, e.l);
                    if (e.l) begin
                        exp_done = 1;
                        frame_on = 0;
                    end
                end
                n_xfer++;
            end
        end else begin
            prev_hold = 0;
            exp_done = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("done2", done2, exp_done2);
            if (exp_done2) seen_done2 = 1;
            exp_done2 = 0;
            if (en && m2.out_valid && m2.out_ready) begin
                if (q2.size() == 0) fail("extra_out2");
                else begin
                    automatic exp_t e = q2.pop_front();
                    chk("out_data2", m2.out_data, e.d);
                    chk("out_last2", m2.out_last, e.l);
                    if (e.l) exp_done2 = 1;
                end
            end
        end else exp_done2 = 0;
    end

    initial forever begin
        @(posedge clk);
        #1;
        m.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic produce(input logic [31:0] v[25], input int gap);
        for (int k = 0; k < 25 && !abort; k++) begin
            automatic bit acc = 0;
            for (int g = 0; g < gap; g++) begin
                m.in_valid = 0;
                @(posedge clk);
                #1;
            end
            m.in_valid = 1;
            m.in_data = v[k];
            for (int t = 0; t < 2000 && !acc && !abort; t++) begin
                @(negedge clk);
                acc = m.in_valid && m.in_ready && en;
                @(posedge clk);
                #1;
            end
            if (!acc && !abort) fail("accept_timeout");
        end
        m.in_valid = 0;
    endtask

    task automatic freeze();
        logic [34:0] snap;
        int t = 0;
        while (n_xfer < 30 && t < 4000) begin @(posedge clk); #1; t++; end
        if (n_xfer < 30) fail("freeze_wait");
        en = 0;
        @(negedge clk);
        snap = {m.out_valid, m.out_last, busy, m.out_data};
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            start = i == 3;
            @(negedge clk);
            chk("frozen", {m.out_valid, m.out_last, busy, m.out_data}, snap);
        end
        @(posedge clk);
        #1;
        start = 0;
        en = 1;
        repeat (3) @(posedge clk);
        #1;
        start = 1;
        @(posedge clk);
        #1;
        start = 0;
    endtask

    task automatic do_reset();
        int t = 0;
        while (n_xfer < 40 && t < 4000) begin @(posedge clk); #1; t++; end
        if (n_xfer < 40) fail("reset_wait");
        chk_on = 0;
        abort = 1;
        reset = 1;
        @(posedge clk);
        #1;
        reset = 0;
        @(negedge clk);
        chk("rst_valid", m.out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", m.in_ready, 0);
        chk("rst_data", m.out_data, 0);
        chk("rst_last", m.out_last, 0);
        q.delete();
        n_xfer = 0;
        frame_on = 0;
        chk_on = 1;
    endtask

    task automatic run_frame(input logic [31:0] base, input bit inc, input int gap, input int ev);
        logic [31:0] v[25];
        for (int k = 0; k < 25; k++) v[k] = inc ? base + 32'(k) : base;
        for (int i = 0; i < 81; i++) begin
            automatic int r = i / 9, c = i % 9;
            q.push_back(exp_t'{d: (r % 2 == 0 && c % 2 == 0) ? v[(r/2)*5 + c/2] : 32'd0, l: i == 80});
        end
        repeat (2) @(posedge clk);
        #1;
        abort = 0;
        n_xfer = 0;
        seen_done = 0;
        start = 1;
        @(posedge clk);
        #1;
        start = 0;
        frame_on = 1;
        fork
            produce(v, gap);
            begin
                if (ev == 5) freeze();
                if (ev == 6) do_reset();
            end
            begin
                for (int t = 0; t < 4000 && !seen_done && !abort; t++) @(negedge clk);
                if (!seen_done && !abort) fail("frame_timeout");
            end
        join
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        m.in_valid = 0;
        m.in_data = 0;
        m.out_ready = 1;
        m2.in_valid = 0;
        m2.in_data = 0;
        m2.out_ready = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("init_valid", m.out_valid, 0);
        chk("init_data", m.out_data, 0);
        chk("init_last", m.out_last, 0);
        chk("init_ready", m.in_ready, 0);
        chk("init_busy", busy, 0);
        chk("init_done", done, 0);
        chk("init_valid2", m2.out_valid, 0);
        @(posedge clk);
        #1;
        reset = 0;
        chk_on = 1;
        run_frame(32'd3, 0, 0, 0);
        for (int i = 0; i < 25; i++) begin
            automatic int r = i / 5, c = i % 5;
            q2.push_back(exp_t'{d: (r >= 1 && r <= 3 && c >= 1 && c <= 3) ? 32'((r-1)*3 + c) : 32'd0, l: i == 24});
        end
        @(posedge clk);
        #1;
        start2 = 1;
        @(posedge clk);
        #1;
        start2 = 0;
        m2.in_valid = 1;
        m2.in_data = 1;
        for (int t = 0; t < 300 && !seen_done2; t++) begin
            @(negedge clk);
            acc2 = m2.in_valid && m2.in_ready;
            @(posedge clk);
            #1;
            if (acc2) begin
                if (m2.in_data == 9) m2.in_valid = 0;
                else m2.in_data = m2.in_data + 1;
            end
        end
        if (!seen_done2) fail("frame2_timeout");
        rnd = 1;
        run_frame(32'd3, 0, 0, 0);
        rnd = 0;
        run_frame(32'd10, 1, 2, 0);
        run_frame(32'd100, 1, 0, 5);
        run_frame(32'd200, 1, 0, 6);
        rnd = 1;
        run_frame(32'd300, 1, 0, 0);
        rnd = 0;
        repeat (3) @(negedge clk);
        chk("q_left", q.size(), 0);
        chk("q2_left", q2.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
